signed_restoring_divider: RTL

Multi-cycle sequential integer divider: the inverse of the team's Booth multiplier. It uses the same start/finish/clock_count handshake so both arithmetic units drop into the same testbench and datapath. It computes quotient and remainder of two WIDTH-bit two's-complement operands using one restoring shift/subtract step per clock. Division truncates toward zero, and the remainder takes the sign of the dividend.

---
 rtl/signed_restoring_divider.sv | 134 +++++++++++++
 1 files changed

// File: rtl/signed_restoring_divider.sv
// signed_restoring_divider: multi-cycle restoring divider, one quotient bit
// per clock. It shares the start/finish/clock_count handshake with the Booth
// multiplier.
// Build option: define DIV_SIGNED_EN for two's-complement operands, where the
// quotient truncates toward zero and the remainder follows the dividend sign.
// Leave it undefined for unsigned operands.
module signed_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish,
  output logic             div_by_zero,
  output logic [7:0]       clock_count
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] m_reg;      // divisor magnitude
  logic [WIDTH-1:0] r_reg;      // partial remainder; always < divisor, so WIDTH bits suffice
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] ld_dvd_mag;
  logic [WIDTH-1:0] ld_dvs_mag;
  logic             ld_sign_q;
  logic             ld_sign_r;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;

  // Two's-complement negate, wrapping at WIDTH bits (so -2^(W-1) maps to itself).
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Conditionally restore the sign of a magnitude.
  function automatic logic [WIDTH-1:0] apply_sign(input logic s, input logic [WIDTH-1:0] x);
    return s ? neg_w(x) : x;
  endfunction

  // Cycle counter increment that sticks at 8'hFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Load-time operand conditioning and the single restoring trial subtraction.
  always_comb begin
    ld_dvd_mag = Dividend;
    ld_dvs_mag = Divisor;
    ld_sign_q  = 1'b0;
    ld_sign_r  = 1'b0;
`ifdef DIV_SIGNED_EN
    ld_sign_q  = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
    ld_sign_r  = Dividend[WIDTH-1];
    ld_dvd_mag = apply_sign(Dividend[WIDTH-1], Dividend);
    ld_dvs_mag = apply_sign(Divisor[WIDTH-1], Divisor);
`endif
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {1'b0, m_reg};
    r_next  = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // Control FSM and datapath: load, WIDTH shift/subtract steps, sign fix-up, hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      m_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      finish      <= 1'b0;
      div_by_zero <= 1'b0;
      clock_count <= 8'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sign_q      <= ld_sign_q;
            sign_r      <= ld_sign_r;
            q_reg       <= ld_dvd_mag;
            m_reg       <= ld_dvs_mag;
            r_reg       <= '0;
            count       <= CW'(WIDTH);
            clock_count <= 8'd0;
            if (Divisor == '0) begin
              // Division by zero completes on the load edge itself.
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= Dividend;
              finish      <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              finish      <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          r_reg       <= r_next;
          q_reg       <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
          count       <= count - CW'(1);
          clock_count <= sat_inc8(clock_count);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          // The overflow case -2^(W-1)/-1 wraps naturally through neg_w.
          quotient    <= apply_sign(sign_q, q_reg);
          remainder   <= apply_sign(sign_r, r_reg);
          clock_count <= sat_inc8(clock_count);
          finish      <= 1'b1;
          state       <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
